// File: rtl/dff_share_arbiter.sv
// Purpose : round-robin arbiter sharing one 8-bit register between four requesters.
// Latency : request to grant is one registered cycle; a write lands on the strobing edge.
// Backpressure: none; requesters simply wait, and a release always costs one dead cycle.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   rst_n   - synchronous active-low reset
//   ena     - enable; gates only the issue of a new grant
//   ui_in   - [3:0] req, [4] release, [5] write strobe, [6] view select, [7] unused
//   uio_in  - write data for the shared register
//   uo_out  - status view {timeout, busy, owner[1:0], grant[3:0]} or the shared register
//   uio_out - constant 0
//   uio_oe  - constant 0 (all uio pins are inputs)
//
// Build option: define DFF_ARB_HOLD_TIMEOUT_EN to bound each grant to MAX_HOLD
// cycles and expose the timeout flag on uo_out[7].
module dff_share_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t     state, state_nxt;
   logic [3:0] grant, grant_nxt;
   logic [1:0] owner, owner_nxt;
   logic [1:0] rr_ptr, rr_ptr_nxt;
   logic [7:0] shared_reg, shared_reg_nxt;

   logic [3:0] req;
   logic       rel;
   logic       wr;
   logic       owner_req;
   logic       win_vld;
   logic [1:0] win;
   logic [1:0] cand;
   logic       hold_hit;
   logic       tflag_view;
   logic       unused_ok;

   assign req       = ui_in[3:0];
   assign rel       = ui_in[4];
   assign wr        = ui_in[5];
   assign owner_req = req[owner];
   assign unused_ok = ui_in[7] ^ (MAX_HOLD > 0) ^ (CNT_W > 0);

`ifdef DFF_ARB_HOLD_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic             timeout_flag, timeout_flag_nxt;

   assign hold_hit   = (hold_cnt == HOLD_LIM);
   assign tflag_view = timeout_flag;
`else
   assign hold_hit   = 1'b0;
   assign tflag_view = 1'b0;
`endif

   // First set request searching upward from rr_ptr, wrapping 3 -> 0.
   always_comb begin
      win_vld = 1'b0;
      win     = rr_ptr;
      cand    = '0;
      for (int i = 0; i < 4; i++) begin
         cand = rr_ptr + 2'(i);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      grant_nxt        = grant;
      owner_nxt        = owner;
      rr_ptr_nxt       = rr_ptr;
      shared_reg_nxt   = shared_reg;
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
      hold_cnt_nxt     = hold_cnt;
      timeout_flag_nxt = timeout_flag;
`endif
      case (state)
         IDLE: begin
            if (ena && win_vld) begin
               owner_nxt = win;
               grant_nxt = 4'b0001 << win;
               state_nxt = GRANT;
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
               hold_cnt_nxt     = CNT_W'(1);
               timeout_flag_nxt = 1'b0;
`endif
            end
         end
         GRANT: begin
            // The write commits even when the same cycle ends the grant.
            if (wr && owner_req) begin
               shared_reg_nxt = uio_in;
            end
            // Grant is cleared on the exit edge so RELEASE already shows no owner.
            if (rel || !owner_req) begin
               grant_nxt = 4'b0000;
               state_nxt = RELEASE;
            end else if (hold_hit) begin
               grant_nxt = 4'b0000;
               state_nxt = RELEASE;
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
               timeout_flag_nxt = 1'b1;
`endif
            end else begin
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
               hold_cnt_nxt = hold_cnt + 1'b1;
`endif
            end
         end
         RELEASE: begin
            grant_nxt  = 4'b0000;
            rr_ptr_nxt = owner + 2'd1;
            state_nxt  = IDLE;
         end
         default: begin
            grant_nxt = 4'b0000;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= 4'b0000;
         owner      <= 2'd0;
         rr_ptr     <= 2'd0;
         shared_reg <= 8'h00;
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
         hold_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         owner      <= owner_nxt;
         rr_ptr     <= rr_ptr_nxt;
         shared_reg <= shared_reg_nxt;
`ifdef DFF_ARB_HOLD_TIMEOUT_EN
         hold_cnt     <= hold_cnt_nxt;
         timeout_flag <= timeout_flag_nxt;
`endif
      end
   end

   always_comb begin
      if (ui_in[6]) begin
         uo_out = shared_reg;
      end else begin
         uo_out = {tflag_view, (state == GRANT), owner, grant};
      end
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit D flip-flop register between four requesters.
- Sits as a Tiny Tapeout user top: `ui_in` carries the request and control lines, `uio_in` carries write data, and `uo_out` shows either status or the shared register.
- Grants exactly one owner at a time. Only the owner may write. Ownership ends on release, on request drop, or on a hold-time limit.

Parameters:
- MAX_HOLD, 15, maximum number of cycles one grant may last (range 2..2^CNT_W-1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; while 0, no new grant is issued.
- ui_in  in  8  [3:0] req[3:0]; [4] release; [5] write strobe; [6] view select (0 = status, 1 = register); [7] unused.
- uio_in  in  8  write data.
- uo_out  out  8  status or register view, selected by ui_in[6].
- uio_out  out  8  tied to 8'h00.
- uio_oe  out  8  tied to 8'h00 (all uio pins are inputs).

Behaviour:
- Synchronous active-low reset, applied on the clk edge with rst_n = 0. Reset values:
  - state = IDLE, grant = 4'b0000, owner = 0, rr_ptr = 0.
  - shared_reg = 8'h00, hold_cnt = 0, timeout_flag = 0.
  - Resulting uo_out = 8'h00 in both views.
- Reset applied mid-grant: grant drops after that edge and any write strobed in the same cycle is discarded.
- State IDLE:
  - Exits only if ena = 1 and req ≠ 0.
  - The winner is the first set req bit searched upward from rr_ptr, wrapping 3→0.
  - On exit: owner = winner, grant = one-hot(winner), hold_cnt = 1, timeout_flag = 0, go to GRANT.
  - Latency: req sampled at edge N produces grant visible from edge N onward (registered, one cycle).
- State GRANT:
  - Write: if ui_in[5] = 1 and req[owner] = 1, shared_reg ← uio_in at that edge. Writes from non-owners cannot occur.
  - Exit to RELEASE if any of the following holds:
    - ui_in[4] = 1;
    - req[owner] = 0;
    - hold_cnt == MAX_HOLD. This case sets timeout_flag = 1.
  - Otherwise hold_cnt increments.
  - A write and a release in the same cycle: the write is committed, then the block releases.
  - The ena value is ignored while in GRANT.
- State RELEASE (always exactly one cycle):
  - grant = 0; rr_ptr = (owner + 1) mod 4; go to IDLE.
  - This guarantees one dead cycle between grants and fairness: a requester that is continuously requesting is served within 4 grants.
- Status view (ui_in[6] = 0), combinational mux of registered values:
  - uo_out[3:0] = grant.
  - uo_out[5:4] = owner.
  - uo_out[6] = (state == GRANT).
  - uo_out[7] = timeout_flag.
- Register view (ui_in[6] = 1): uo_out = shared_reg.
- shared_reg holds its value across grants. It is cleared only by reset.
- timeout_flag is sticky until the next grant is issued.

Optional Feature:
- Macro: DFF_ARB_HOLD_TIMEOUT_EN.
- Defined: the MAX_HOLD limit and timeout_flag operate as described above.
- Undefined:
  - hold_cnt and the timeout exit are removed; a grant lasts until release or request drop.
  - uo_out[7] in status view reads 0.

Test Plan:
- Reset sequence: hold rst_n = 0 for 2 cycles with req = 4'hF, then release reset → uo_out = 8'h00 in both views and grant = 0 on the first cycle after reset.
- Single requester: req = 4'b0100 → next cycle status view = 8'h64 (grant = 0100, owner = 2, busy = 1). Write with uio_in = 8'hA5, then view = 1 → uo_out = 8'hA5.
- Round-robin fairness: hold req = 4'hF and pulse release each grant → grant order 0, 1, 2, 3, 0, with one grant = 0 cycle between consecutive grants.
- Timeout, with the macro defined and MAX_HOLD = 15: req = 4'b0001 held with no release → grant lasts exactly 15 cycles, then status = 8'h80 for the RELEASE cycle, then the block re-grants owner 0 and timeout_flag clears.
- Write and release in the same cycle (owner 1): uio_in = 8'h3C with ui_in[5] = 1 and ui_in[4] = 1 → shared_reg = 8'h3C and the grant drops the next cycle. A write strobe after that is ignored (shared_reg stays 8'h3C).
- ena gating: ena = 0 with req = 4'b1000 → no grant for 5 cycles. Setting ena = 1 → grant = 1000 on the next cycle.
